// File: rtl/nor_chain_sweeper.sv
// nor_chain_sweeper: self-test sequencer for the cascaded NOR chain,
// sweeps all 16 input vectors and checks e/f/g against a reference model.
module nor_chain_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       vec_a,
    output logic       vec_b,
    output logic       vec_c,
    output logic       vec_d,
    input  logic       obs_e,
    input  logic       obs_f,
    input  logic       obs_g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
    state_t state, state_n;
    logic [3:0] idx, idx_n, vec;
    logic [7:0] cnt, cnt_n;
    logic [4:0] err_n;
    logic [3:0] ff_vec_n;
    logic       ff_valid_n, busy_n, exp_e, exp_f, exp_g, mismatch;

    assign exp_e    = ~(idx[3] | idx[2]);
    assign exp_f    = ~(idx[1] | exp_e);
    assign exp_g    = ~(idx[0] | exp_f);
    assign mismatch = {obs_e, obs_f, obs_g} != {exp_e, exp_f, exp_g};
    assign busy_n   = (state_n == SETTLE) || (state_n == CHECK);
    assign {vec_a, vec_b, vec_c, vec_d} = vec;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        err_n      = err_count;
        ff_vec_n   = first_fail_vec;
        ff_valid_n = first_fail_valid;
        case (state)
            IDLE, DONE: if (start) begin
                state_n    = SETTLE;
                idx_n      = 4'd0;
                cnt_n      = 8'(SETTLE_CYCLES - 1);
                err_n      = 5'd0;
                ff_vec_n   = 4'd0;
                ff_valid_n = 1'b0;
            end
            SETTLE: begin
                state_n = abort ? IDLE : (cnt == 8'd0) ? CHECK : SETTLE;
                cnt_n   = (cnt == 8'd0) ? cnt : cnt - 8'd1;
            end
            CHECK: if (abort) state_n = IDLE;
            else begin
                // the first mismatching vector is latched once per sweep
                if (mismatch) begin
                    err_n      = err_count + 5'd1;
                    ff_vec_n   = first_fail_valid ? first_fail_vec : idx;
                    ff_valid_n = 1'b1;
                end
                state_n = (idx == 4'd15) ? DONE : SETTLE;
                idx_n   = (idx == 4'd15) ? idx : idx + 4'd1;
                cnt_n   = 8'(SETTLE_CYCLES - 1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= 4'd0;
            cnt              <= 8'd0;
            vec              <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 5'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_n;
            idx              <= idx_n;
            cnt              <= cnt_n;
            vec              <= busy_n ? idx_n : 4'd0;
            busy             <= busy_n;
            done             <= state_n == DONE;
            pass             <= (state_n == DONE) && (err_n == 5'd0);
            err_count        <= err_n;
            first_fail_vec   <= ff_vec_n;
            first_fail_valid <= ff_valid_n;
        end
    end
endmodule

// File: tb/tb_nor_chain_sweeper.sv
// tb_nor_chain_sweeper: directed bench for nor_chain_sweeper driving an
// attached NOR chain model with selectable stuck-at faults.
module tb_nor_chain_sweeper;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic vec_a, vec_b, vec_c, vec_d, obs_e, obs_f, obs_g;
    logic busy, done, pass, first_fail_valid;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec, vec;
    int mode = 0;
    int n_chk = 0, n_fail = 0;
    int busy_cnt, done_cyc, vec_bad;

    typedef struct {
        int mode;
        int err;
        int ffv;
        int ffvec;
        int pass_e;
    } sweep_t;
    sweep_t tbl[3];

    nor_chain_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec_a(vec_a), .vec_b(vec_b), .vec_c(vec_c), .vec_d(vec_d),
        .obs_e(obs_e), .obs_f(obs_f), .obs_g(obs_g),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
    );

    always #5 clk = ~clk;
    assign vec = {vec_a, vec_b, vec_c, vec_d};

    // chain model: mode 1 = g stuck-at-0, mode 2 = internal e stuck-at-1
    always_comb begin
        obs_e = (mode == 2) ? 1'b1 : ~(vec_a | vec_b);
        obs_f = ~(vec_c | obs_e);
        obs_g = (mode == 1) ? 1'b0 : ~(vec_d | obs_f);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // start sampled in cycle 0; abort raised in cycle ab; start held in lo..hi
    task automatic sweep(input int ab, input int lo, input int hi);
        int c;
        busy_cnt = 0;
        done_cyc = 0;
        vec_bad  = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        c = 1;
        while (c < 200) begin
            if (busy) begin
                busy_cnt++;
                if (vec != 4'((c - 1) / 3)) vec_bad++;
            end else if (vec != 4'd0) vec_bad++;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (c == ab) begin
                abort = 1'b1;
                @(negedge clk) abort = 1'b0;
                break;
            end
            start = (c >= lo && c <= hi);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 0,  0, 0, 1};
        tbl[1] = '{1, 5,  1, 0, 0};
        tbl[2] = '{2, 12, 1, 4, 0};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ffv", first_fail_valid, 0);
        chk("rst_ffvec", first_fail_vec, 0);
        chk("rst_vec", vec, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].mode;
            sweep(0, 0, 0);
            chk($sformatf("sw%0d_busy_cycles", i), busy_cnt, 48);
            chk($sformatf("sw%0d_done_cycle", i), done_cyc, 49);
            chk($sformatf("sw%0d_vec_seq_errs", i), vec_bad, 0);
            chk($sformatf("sw%0d_err", i), err_count, tbl[i].err);
            chk($sformatf("sw%0d_ffv", i), first_fail_valid, tbl[i].ffv);
            chk($sformatf("sw%0d_ffvec", i), first_fail_vec, tbl[i].ffvec);
            chk($sformatf("sw%0d_pass", i), pass, tbl[i].pass_e);
            chk($sformatf("sw%0d_vec_done", i), vec, 0);
            repeat (2) @(negedge clk);
        end

        // abort at cycle 20: vectors 0..5 checked, g-stuck faults at 0 and 2
        mode = 1;
        sweep(20, 0, 0);
        chk("abort_busy", busy, 0);
        chk("abort_vec", vec, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_count, 2);
        chk("abort_ffv", first_fail_valid, 1);
        chk("abort_ffvec", first_fail_vec, 0);
        repeat (3) @(negedge clk);
        chk("abort_idle_done", done, 0);
        chk("abort_idle_busy", busy, 0);

        // start held mid-run must not restart the sweep
        mode = 0;
        sweep(0, 5, 10);
        chk("hold_vec_seq_errs", vec_bad, 0);
        chk("hold_done_cycle", done_cyc, 49);
        chk("hold_pass", pass, 1);

        // asynchronous reset between clock edges
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_err", err_count, 2);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vec", vec, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_ffv", first_fail_valid, 0);
        @(negedge clk) rst = 1'b0;
        mode = 0;
        sweep(0, 0, 0);
        chk("post_rst_busy_cycles", busy_cnt, 48);
        chk("post_rst_done_cycle", done_cyc, 49);
        chk("post_rst_vec_seq_errs", vec_bad, 0);
        chk("post_rst_pass", pass, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nor_chain_sweeper.md
Name: nor_chain_sweeper

Overview:
- Sequencer/checker for the 4-input cascaded NOR chain datapath (e = ~(a|b), f = ~(c|e), g = ~(d|f)).
- On start, drives all 16 input combinations onto the chain one at a time and waits a programmable settle time per vector.
- Samples e/f/g and compares them against an internal reference model; reports mismatch count, first failing vector and pass/fail.
- Sits beside the NOR chain on the lab board as its self-test controller.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level-sampled; begins a sweep when in IDLE or DONE
- abort  input  1  aborts a running sweep and returns to IDLE
- vec_a  output  1  drive to chain input a (vector index bit 3)
- vec_b  output  1  drive to chain input b (index bit 2)
- vec_c  output  1  drive to chain input c (index bit 1)
- vec_d  output  1  drive to chain input d (index bit 0)
- obs_e  input  1  chain output e
- obs_f  input  1  chain output f
- obs_g  input  1  chain output g
- busy  output  1  high in SETTLE and CHECK
- done  output  1  high in DONE
- pass  output  1  done && err_count==0
- err_count  output  5  vectors with any mismatch, 0..16
- first_fail_vec  output  4  index of first mismatching vector
- first_fail_valid  output  1  first_fail_vec holds a captured index

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset: state = IDLE, idx = 0, vec_* = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail_vec = 0, first_fail_valid = 0.
- Reset asserted mid-sweep takes effect immediately, without waiting for a clock edge.
- All outputs are registered; {vec_a, vec_b, vec_c, vec_d} = idx whenever busy, and 0 otherwise.
- States:
  - IDLE: start=1 -> clear err_count/first_fail_*, idx = 0, cnt = SETTLE_CYCLES-1, go SETTLE.
  - SETTLE: vector held; cnt decrements each cycle; at cnt==0 go CHECK. Lasts exactly SETTLE_CYCLES cycles.
  - CHECK: one cycle; sample obs_*.
    - Compute expected e = ~(a|b), f = ~(c|e_exp), g = ~(d|f_exp) from idx.
    - If any of e/f/g differs, increment err_count. On the first mismatch only, capture first_fail_vec = idx and set first_fail_valid = 1.
    - If idx==15 go DONE; else idx++, cnt = SETTLE_CYCLES-1, go SETTLE.
  - DONE: done = 1, pass valid, results held. start=1 -> same as from IDLE (restart, results cleared).
- Latency: the cycle start is sampled is cycle 0. busy rises at cycle 1; done rises at cycle 16*(SETTLE_CYCLES+1)+1.
- start while busy is ignored.
- abort while busy -> IDLE next cycle; vec_* = 0, done stays 0, err_count/first_fail_* keep their partial values.
- abort in IDLE or DONE has no effect; abort has priority over start in the same cycle.
- err_count saturates naturally at 16 (5 bits, no wrap).
- obs_* are treated as synchronous to clk; no synchronizer is required.

Test Plan:
- Ideal NOR chain model attached, SETTLE_CYCLES=2, pulse start -> busy for 48 cycles, done at cycle 49, err_count=0, pass=1, first_fail_valid=0.
- Model with obs_g stuck-at-0 -> err_count=5 (vectors 0, 2, 6, 10, 14), first_fail_vec=0, pass=0.
- Model with internal e stuck-at-1 -> err_count=12, first_fail_vec=4 (0100), pass=0.
- Monitor vec_* during an ideal run -> each index 0..15 is held for exactly 3 cycles, in ascending order; vec_* = 0 in DONE.
- abort at cycle 20 of a run -> IDLE next cycle, vec_*=0, done=0; start held high during cycles 5..10 of a fresh run does not restart it (idx still advances monotonically).
- rst asserted mid-sweep between clock edges -> all outputs 0 immediately; after release, start yields a full clean 48-cycle sweep with pass=1.
